// File: rtl/hb_interp_fir.sv
// hb_interp_fir
//   11-tap half-band interpolation FIR for the Tx chain. It sits directly
//   after the L=2 zero-stuffing upsampler and runs at the fast rate. It removes
//   the zero-stuffing image and applies a gain of 2 to restore amplitude.
//
//   Datapath (free-running pipeline behind a valid-gated delay line):
//     taps -> S1 pre-add -> S2 multiply -> S3 sum -> S4 round/saturate -> dout
//   Latency: 4 clocks from the edge that loads din into tap[0] to the edge
//   that updates dout with the result that includes that sample.
//
// Ports:
//   clk         in   fast-rate clock
//   rst         in   synchronous, active-high reset
//   din_valid   in   din carries a sample this cycle (delay line shifts)
//   din         in   signed zero-stuffed input sample, WIDTH bits
//   dout        out  signed filtered output, OUT_W bits
//   dout_valid  out  dout holds a new result
module hb_interp_fir #(
  parameter int WIDTH  = 23,
  parameter int OUT_W  = 23,
  parameter int COEF_W = 18,
  parameter int H0     = 1232,
  parameter int H2     = -7301,
  parameter int H4     = 38837
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din_valid,
  input  logic signed [WIDTH-1:0] din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    dout_valid
);

  localparam int NTAP = 11;
  localparam int PW   = WIDTH + 1;
  localparam int MW   = WIDTH + 1 + COEF_W;
  localparam int SW   = WIDTH + COEF_W + 3;
  localparam int SH   = COEF_W - 2;

  localparam logic signed [COEF_W-1:0] C0 = COEF_W'(H0);
  localparam logic signed [COEF_W-1:0] C2 = COEF_W'(H2);
  localparam logic signed [COEF_W-1:0] C4 = COEF_W'(H4);

  localparam logic signed [SW-1:0] RND   = SW'(1) << (COEF_W - 3);
  localparam logic signed [SW-1:0] O_MAX = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] O_MIN = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [WIDTH-1:0] tap [0:NTAP-1];

  logic signed [PW-1:0]    p0, p2, p4;
  logic signed [WIDTH-1:0] c5;
  logic signed [MW-1:0]    m0, m2, m4, mc;
  logic signed [SW-1:0]    s;
  logic signed [SW-1:0]    r_full;
  logic [3:0]              vld_sr;

  // Delay line. Odd taps (other than the centre) have zero coefficients and
  // are only ever used as shift-register storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NTAP; k++) tap[k] <= '0;
    end else if (din_valid) begin
      tap[0] <= din;
      for (int k = 1; k < NTAP; k++) tap[k] <= tap[k-1];
    end
  end

  // S1..S3 run every cycle regardless of din_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      p0 <= '0;
      p2 <= '0;
      p4 <= '0;
      c5 <= '0;
      m0 <= '0;
      m2 <= '0;
      m4 <= '0;
      mc <= '0;
      s  <= '0;
    end else begin
      p0 <= PW'(tap[0]) + PW'(tap[10]);
      p2 <= PW'(tap[2]) + PW'(tap[8]);
      p4 <= PW'(tap[4]) + PW'(tap[6]);
      c5 <= tap[5];

      m0 <= MW'(p0) * MW'(C0);
      m2 <= MW'(p2) * MW'(C2);
      m4 <= MW'(p4) * MW'(C4);
      // Centre coefficient is exactly 0.5 in Q1.(COEF_W-1): a shift, not a multiply.
      mc <= MW'(c5) <<< SH;

      s  <= SW'(m0) + SW'(m2) + SW'(m4) + SW'(mc);
    end
  end

  // Round half up, then drop COEF_W-2 fraction bits; dropping one bit fewer
  // than the Q format carries is what yields the net gain of 2.
  always_comb begin
    r_full = (s + RND) >>> SH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else if (r_full > O_MAX) begin
      dout <= O_MAX[OUT_W-1:0];
    end else if (r_full < O_MIN) begin
      dout <= O_MIN[OUT_W-1:0];
    end else begin
      dout <= r_full[OUT_W-1:0];
    end
  end

  // Valid travels alongside its sample: tap load, S1, S2, S3, then output,
  // so dout_valid rises on the same edge as the matching dout.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr     <= '0;
      dout_valid <= 1'b0;
    end else begin
      vld_sr     <= {vld_sr[2:0], din_valid};
      dout_valid <= vld_sr[3];
    end
  end

endmodule

// File: tb/tb_hb_interp_fir.sv
module tb_hb_interp_fir;

  logic               clk;
  logic               rst;
  logic               din_valid;
  logic signed [22:0] din;
  logic signed [22:0] dout;
  logic               dout_valid;

  hb_interp_fir dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int first_nz = -1;

  // Reference: direct-form convolution over the accepted-sample history,
  // followed by a plain 4-cycle latency queue.
  int     coef [0:10] = '{1232, 0, -7301, 0, 38837, 65536, 38837, 0, -7301, 0, 1232};
  longint hist [0:10];
  longint pd   [0:3];
  bit     pv   [0:3];
  longint cap  [$];

  function automatic longint fir_ref();
    longint acc;
    longint r;
    acc = 0;
    for (int k = 0; k < 11; k++) acc += longint'(coef[k]) * hist[k];
    r = (acc + 32768) >>> 16;
    if (r > 4194303) r = 4194303;
    else if (r < -4194304) r = -4194304;
    return r;
  endfunction

  task automatic check(input string tag, input longint obs, input longint expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step(input logic signed [22:0] d, input logic v, input logic r);
    longint             e_d;
    logic               e_v;
    logic signed [22:0] e_d23;
    din       = d;
    din_valid = v;
    rst       = r;
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 11; k++) hist[k] = 0;
      for (int k = 0; k < 4; k++) begin pd[k] = 0; pv[k] = 1'b0; end
      e_d = 0;
      e_v = 1'b0;
    end else begin
      e_d = pd[3];
      e_v = pv[3];
      for (int k = 3; k > 0; k--) begin pd[k] = pd[k-1]; pv[k] = pv[k-1]; end
      if (v) begin
        for (int k = 10; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = longint'(d);
      end
      pd[0] = fir_ref();
      pv[0] = v;
    end
    #1;
    e_d23 = e_d[22:0];
    n_assert++;
    assert (dout === e_d23) else begin
      n_fail++;
      $error("FAIL dout cyc=%0d observed=%0d expected=%0d", cyc, dout, e_d23);
    end
    n_assert++;
    assert (dout_valid === e_v) else begin
      n_fail++;
      $error("FAIL dout_valid cyc=%0d observed=%0b expected=%0b", cyc, dout_valid, e_v);
    end
    if (dout_valid === 1'b1) cap.push_back(longint'(dout));
    if (first_nz < 0 && dout !== 23'sd0) first_nz = cyc;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(23'sd0, 1'b0, 1'b1);
    cap.delete();
    first_nz = -1;
  endtask

  initial begin
    longint             imp_exp [0:10];
    int                 imp_cyc;
    logic signed [22:0] rd;
    logic               rv;
    logic               rr;
    imp_exp = '{19, 0, -111, 0, 593, 1000, 593, 0, -111, 0, 19};
    for (int k = 0; k < 11; k++) hist[k] = 0;
    for (int k = 0; k < 4; k++) begin pd[k] = 0; pv[k] = 1'b0; end
    rst = 1'b1; din_valid = 1'b0; din = '0;

    // Reset state
    do_reset(3);
    check("reset_dout", longint'(dout), 0);
    check("reset_valid", longint'(dout_valid), 0);

    // Impulse response, din_valid held high
    imp_cyc = cyc;
    step(23'sd1000, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(23'sd0, 1'b1, 1'b0);
    check("imp_latency", longint'(first_nz - imp_cyc), 4);
    check("imp_count_ge11", longint'(cap.size() >= 11), 1);
    for (int k = 0; k < 11; k++)
      if (k < cap.size()) check($sformatf("imp_y%0d", k), cap[k], imp_exp[k]);

    // Impulse with din_valid low every other cycle
    do_reset(2);
    step(23'sd1000, 1'b1, 1'b0);
    for (int i = 1; i < 30; i++) step(23'sd0, (i % 2 == 0), 1'b0);
    check("gate_count_ge11", longint'(cap.size() >= 11), 1);
    for (int k = 0; k < 11; k++)
      if (k < cap.size()) check($sformatf("gate_y%0d", k), cap[k], imp_exp[k]);

    // DC through upsampler pattern, with a mid-stream reset
    do_reset(2);
    for (int i = 0; i < 40; i++) begin
      step((i % 2 == 0) ? 23'sd10000 : 23'sd0, 1'b1, 1'b0);
      if (i >= 16) check("dc_settled", longint'(dout), 10000);
    end
    step(23'sd10000, 1'b1, 1'b1);
    check("midrst_dout", longint'(dout), 0);
    check("midrst_valid", longint'(dout_valid), 0);
    for (int i = 0; i < 24; i++) step((i % 2 == 0) ? 23'sd10000 : 23'sd0, 1'b1, 1'b0);
    check("dc_rebuilt", longint'(dout), 10000);

    // Saturation
    do_reset(2);
    for (int i = 0; i < 20; i++) step(23'sd4194303, 1'b1, 1'b0);
    check("sat_pos", longint'(dout), 4194303);
    for (int i = 0; i < 20; i++) step(-23'sd4194304, 1'b1, 1'b0);
    check("sat_neg", longint'(dout), -4194304);

    // Rounding with a -1 impulse
    do_reset(2);
    step(-23'sd1, 1'b1, 1'b0);
    for (int i = 0; i < 18; i++) step(23'sd0, 1'b1, 1'b0);
    if (cap.size() >= 11) begin
      check("rnd_h0", cap[0], 0);
      check("rnd_centre", cap[5], -1);
    end else begin
      check("rnd_count_ge11", longint'(cap.size()), 11);
    end

    // Randomised traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      rr = ($urandom_range(63) == 0);
      rv = ($urandom_range(3) != 0);
      rd = 23'($urandom);
      if ($urandom_range(1) == 1) rd = '0;
      step(rd, rv, rr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
